id_ex_alu_stage: RTL and testbench

- Single-entry ID/EX pipeline register feeding the 32-bit ALU (A, B, 4-bit OP).
- Captures decoded operands and control, performs ALU-control decode (alu_op/funct to OP) and immediate sign-extension/operand select.
- Presents registered A/B/OP to the ALU one cycle later.
- valid/ready handshake on both sides with stall back-pressure; flush for branch/hazard squash.

---
 rtl/id_ex_alu_stage_if.sv | 46 ++++
 rtl/id_ex_alu_stage.sv | 69 ++++++
 tb/tb_id_ex_alu_stage.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/id_ex_alu_stage_if.sv
// id_ex_alu_stage_if: ID/EX handshake and operand bus; forwarding signals exist only when ALU_FWD_EN is defined
interface id_ex_alu_stage_if #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [IMM_W-1:0]  imm;
  logic              alu_src;
  logic [1:0]        alu_op;
  logic [5:0]        funct;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [3:0]        OP;
  logic              illegal;
`ifdef ALU_FWD_EN
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic [DATA_W-1:0] exmem_res;
  logic [DATA_W-1:0] memwb_res;
  modport master (
    output in_valid, rs_data, rt_data, imm, alu_src, alu_op, funct, flush, out_ready,
           fwd_a_sel, fwd_b_sel, exmem_res, memwb_res,
    input  in_ready, out_valid, A, B, OP, illegal
  );
  modport slave (
    input  in_valid, rs_data, rt_data, imm, alu_src, alu_op, funct, flush, out_ready,
           fwd_a_sel, fwd_b_sel, exmem_res, memwb_res,
    output in_ready, out_valid, A, B, OP, illegal
  );
`else
  modport master (
    output in_valid, rs_data, rt_data, imm, alu_src, alu_op, funct, flush, out_ready,
    input  in_ready, out_valid, A, B, OP, illegal
  );
  modport slave (
    input  in_valid, rs_data, rt_data, imm, alu_src, alu_op, funct, flush, out_ready,
    output in_ready, out_valid, A, B, OP, illegal
  );
`endif
endinterface

// File: rtl/id_ex_alu_stage.sv
// id_ex_alu_stage: single-entry ID/EX register with ALU-control decode and operand select; ALU_FWD_EN adds operand forwarding
module id_ex_alu_stage #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input logic               clk,
  input logic               rst_n,
  id_ex_alu_stage_if.slave  bus
);
  localparam logic [3:0] OP_NOP = 4'b1111;
  logic              valid_q, valid_d, ill_q, ill_d, load, clr, ill_dec;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, a_src, rt_src, imm_ext;
  logic [3:0]        op_q, op_d, op_dec, funct_op;
  assign bus.in_ready  = !valid_q || bus.out_ready;
  assign load          = bus.in_valid && bus.in_ready && !bus.flush;
  assign clr           = bus.flush || (bus.in_ready && !load);
  assign imm_ext       = {{(DATA_W-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
  assign bus.out_valid = valid_q;
  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.OP        = op_q;
  assign bus.illegal   = ill_q;
  // choose forwarded or register-file operands ahead of the pipeline register
  always_comb begin
`ifdef ALU_FWD_EN
    a_src  = bus.fwd_a_sel == 2'b01 ? bus.exmem_res : bus.fwd_a_sel == 2'b10 ? bus.memwb_res : bus.rs_data;
    rt_src = bus.fwd_b_sel == 2'b01 ? bus.exmem_res : bus.fwd_b_sel == 2'b10 ? bus.memwb_res : bus.rt_data;
`else
    a_src  = bus.rs_data;
    rt_src = bus.rt_data;
`endif
  end
  // ALU-control decode; funct 000000 is a legal NOP, any other unknown funct is flagged
  always_comb begin
    funct_op = bus.funct == 6'b100000 ? 4'b0010 :
               bus.funct == 6'b100010 ? 4'b0110 :
               bus.funct == 6'b100100 ? 4'b0000 :
               bus.funct == 6'b100101 ? 4'b0001 :
               bus.funct == 6'b101010 ? 4'b0111 : OP_NOP;
    op_dec   = bus.alu_op == 2'b00 ? 4'b0010 :
               bus.alu_op == 2'b01 ? 4'b0110 :
               bus.alu_op == 2'b10 ? funct_op : OP_NOP;
    ill_dec  = bus.alu_op == 2'b10 && funct_op == OP_NOP && bus.funct != 6'b000000;
  end
  // next state: load a new instruction, clear to NOP when empty or flushed, otherwise hold
  always_comb begin
    valid_d = clr ? 1'b0 : load ? 1'b1 : valid_q;
    a_d     = clr ? '0 : load ? a_src : a_q;
    b_d     = clr ? '0 : load ? (bus.alu_src ? imm_ext : rt_src) : b_q;
    op_d    = clr ? OP_NOP : load ? op_dec : op_q;
    ill_d   = clr ? 1'b0 : load ? ill_dec : ill_q;
  end
  // pipeline register with synchronous active-low reset to an idle NOP
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_NOP;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      ill_q   <= ill_d;
    end
  end
endmodule

// File: tb/tb_id_ex_alu_stage.sv
// tb_id_ex_alu_stage: directed scoreboard bench for id_ex_alu_stage; exercises forwarding when ALU_FWD_EN is defined
module tb_id_ex_alu_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int passed = 0;
  int burst_stalls = 0;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        ill;
  } exp_t;
  exp_t sb[$];
  exp_t got_m, exp_m;

  id_ex_alu_stage_if #(.DATA_W(32), .IMM_W(16)) bus ();
  id_ex_alu_stage #(.DATA_W(32), .IMM_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                        input logic src, input logic [1:0] aop, input logic [5:0] fn);
    bus.in_valid = 1'b1;
    bus.rs_data  = rs;
    bus.rt_data  = rt;
    bus.imm      = imm;
    bus.alu_src  = src;
    bus.alu_op   = aop;
    bus.funct    = fn;
  endtask

  task automatic send(input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                      input logic src, input logic [1:0] aop, input logic [5:0] fn, input exp_t e);
    int n;
    set_in(rs, rt, imm, src, aop, fn);
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      total++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
    end else sb.push_back(e);
    burst_stalls += n;
    step();
  endtask

  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      got_m = {bus.A, bus.B, bus.OP, bus.illegal};
      total++;
      if (sb.size() == 0) $display("FAIL spurious_output: got A=%h B=%h OP=%b ill=%b, required no output",
                                   got_m.a, got_m.b, got_m.op, got_m.ill);
      else begin
        exp_m = sb.pop_front();
        if (got_m === exp_m) passed++;
        else $display("FAIL transfer: got A=%h B=%h OP=%b ill=%b, required A=%h B=%h OP=%b ill=%b",
                      got_m.a, got_m.b, got_m.op, got_m.ill, exp_m.a, exp_m.b, exp_m.op, exp_m.ill);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  initial begin
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
`ifdef ALU_FWD_EN
    bus.fwd_a_sel = 2'b00;
    bus.fwd_b_sel = 2'b00;
    bus.exmem_res = 32'h0;
    bus.memwb_res = 32'h0;
`endif
    set_in(32'h5, 32'h7, 16'h0, 1'b0, 2'b10, 6'b100000);
    rst_n = 1'b0;
    step();
    step();
    @(negedge clk);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_OP", 64'(bus.OP), 64'hF);
    check("reset_A", 64'(bus.A), 64'd0);
    check("reset_B", 64'(bus.B), 64'd0);
    check("reset_illegal", 64'(bus.illegal), 64'd0);
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    step();
    burst_stalls = 0;
    send(32'h5, 32'h7, 16'h1234, 1'b0, 2'b10, 6'b100000, '{32'h5, 32'h7, 4'b0010, 1'b0});
    send(32'hA, 32'h3, 16'h0, 1'b0, 2'b10, 6'b100010, '{32'hA, 32'h3, 4'b0110, 1'b0});
    send(32'hF0, 32'h3C, 16'h0, 1'b0, 2'b10, 6'b100100, '{32'hF0, 32'h3C, 4'b0000, 1'b0});
    send(32'hF0, 32'h0F, 16'h0, 1'b0, 2'b10, 6'b100101, '{32'hF0, 32'h0F, 4'b0001, 1'b0});
    send(32'hFFFFFFFF, 32'h1, 16'h0, 1'b0, 2'b10, 6'b101010, '{32'hFFFFFFFF, 32'h1, 4'b0111, 1'b0});
    send(32'h11, 32'h22, 16'h0, 1'b0, 2'b10, 6'b000000, '{32'h11, 32'h22, 4'b1111, 1'b0});
    send(32'h33, 32'h44, 16'h0, 1'b0, 2'b11, 6'b100000, '{32'h33, 32'h44, 4'b1111, 1'b0});
    send(32'h100, 32'hDEAD, 16'hFFFC, 1'b1, 2'b00, 6'b0, '{32'h100, 32'hFFFFFFFC, 4'b0010, 1'b0});
    send(32'h4, 32'h5, 16'h8000, 1'b1, 2'b01, 6'b0, '{32'h4, 32'hFFFF8000, 4'b0110, 1'b0});
    send(32'h6, 32'hBEEF, 16'h7FFF, 1'b1, 2'b00, 6'b0, '{32'h6, 32'h00007FFF, 4'b0010, 1'b0});
    send(32'h1, 32'h2, 16'h0, 1'b0, 2'b10, 6'b001000, '{32'h1, 32'h2, 4'b1111, 1'b1});
    bus.in_valid = 1'b0;
    check("burst_no_bubbles", 64'(burst_stalls), 64'd0);
    step();
    @(negedge clk);
    check("drain_out_valid", 64'(bus.out_valid), 64'd0);
    check("drain_OP", 64'(bus.OP), 64'hF);
    check("drain_AB", {bus.A, bus.B}, 64'd0);
    step();
    bus.out_ready = 1'b0;
    send(32'h20, 32'h20, 16'h0, 1'b0, 2'b01, 6'b0, '{32'h20, 32'h20, 4'b0110, 1'b0});
    set_in(32'h1, 32'h2, 16'h0, 1'b0, 2'b10, 6'b100000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(bus.in_ready), 64'd0);
      check("stall_out_valid", 64'(bus.out_valid), 64'd1);
      check("stall_hold", {24'd0, bus.A[15:0], bus.B[15:0], 4'd0, bus.OP}, {24'd0, 16'h20, 16'h20, 8'h06});
    end
    step();
    bus.out_ready = 1'b1;
    send(32'h1, 32'h2, 16'h0, 1'b0, 2'b10, 6'b100000, '{32'h1, 32'h2, 4'b0010, 1'b0});
    bus.in_valid = 1'b0;
    step();
    step();
    bus.out_ready = 1'b0;
    set_in(32'h77, 32'h88, 16'h0, 1'b0, 2'b00, 6'b0);
    step();
    @(negedge clk);
    check("flush_pre_valid", 64'(bus.out_valid), 64'd1);
    set_in(32'h99, 32'hAA, 16'h0, 1'b0, 2'b10, 6'b100010);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush_OP", 64'(bus.OP), 64'hF);
    check("flush_A", 64'(bus.A), 64'd0);
    check("flush_B", 64'(bus.B), 64'd0);
    check("flush_illegal", 64'(bus.illegal), 64'd0);
    step();
    bus.out_ready = 1'b1;
    step();
    step();
    bus.out_ready = 1'b0;
    set_in(32'h55, 32'h66, 16'h0, 1'b0, 2'b00, 6'b0);
    step();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_out_valid", 64'(bus.out_valid), 64'd0);
    step();
    bus.out_ready = 1'b1;
    step();
    step();
`ifdef ALU_FWD_EN
    bus.fwd_a_sel = 2'b01;
    bus.exmem_res = 32'h9;
    bus.memwb_res = 32'hAB;
    send(32'h1, 32'h2, 16'h0, 1'b0, 2'b10, 6'b100000, '{32'h9, 32'h2, 4'b0010, 1'b0});
    bus.fwd_a_sel = 2'b10;
    bus.fwd_b_sel = 2'b10;
    send(32'h1, 32'h2, 16'h0, 1'b0, 2'b10, 6'b100010, '{32'hAB, 32'hAB, 4'b0110, 1'b0});
    bus.fwd_a_sel = 2'b11;
    bus.fwd_b_sel = 2'b01;
    send(32'h3, 32'h4, 16'hFFF0, 1'b1, 2'b00, 6'b0, '{32'h3, 32'hFFFFFFF0, 4'b0010, 1'b0});
    bus.fwd_b_sel = 2'b11;
    send(32'h3, 32'h4, 16'h0, 1'b0, 2'b10, 6'b100100, '{32'h3, 32'h4, 4'b0000, 1'b0});
    bus.fwd_a_sel = 2'b00;
    bus.fwd_b_sel = 2'b00;
    bus.in_valid = 1'b0;
`endif
    step();
    step();
    step();
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
